uart_tx_fifo: RTL

Memory-mapped UART transmitter that sits directly downstream of the CPU store path and drives the CPU top-level `uart` output pin. A store to the UART address raises `wr_en` with the low byte on `wr_data`, and the block queues that byte in a FIFO. Because the single-cycle core cannot stall, stores complete in one cycle and the block serialises queued bytes as 8N1 frames, with optional even parity.

---
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter, with a registered serial line.
// Optional even parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          uart,
  output logic          tx_busy,
  output logic          fifo_full,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int          AW        = CW - 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            uart_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
  logic [7:0]      mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            par_q;
`endif

  logic baud_done, pop, push;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign baud_done  = (baud_q == BAUD_LAST);
  assign pop        = (state_q == IDLE) && (count_q != '0);
  // Full is judged on the pre-edge count, so a same-edge pop never rescues a write.
  assign push       = wr_en && !fifo_full;

  // NOTE: every variable driven here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop)       state_d = START;
      START: if (baud_done) state_d = DATA;
      DATA: begin
        if (baud_done && bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_done) state_d = STOP;
`endif
      STOP:  if (baud_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      uart_q  <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= (state_d != state_q || baud_done || state_q == IDLE) ? '0 : baud_q + 16'd1;

      if (pop) begin
        shreg_q <= mem[rd_ptr];
        bit_q   <= '0;
        rd_ptr  <= rd_ptr + AW'(1);
`ifdef UART_TX_PARITY_EN
        par_q   <= ^mem[rd_ptr];
`endif
      end else if (state_q == DATA && baud_done) begin
        shreg_q <= shreg_q >> 1;
        bit_q   <= bit_q + 3'd1;
      end

      // The line lags the state by one cycle, so it is glitch-free and fully registered.
      case (state_q)
        START:   uart_q <= 1'b0;
        DATA:    uart_q <= shreg_q[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  uart_q <= par_q;
`endif
        default: uart_q <= 1'b1;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (wr_en && fifo_full) ovf_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the data array is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign uart       = uart_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign tx_busy    = (state_q != IDLE) || (count_q != '0);

endmodule
